// File: rtl/cs_pkg.sv
`default_nettype none
// ============================================================================
// cs_pkg : widths, polynomials and FSM encoding shared by the CS test partners
// Revision: 1.0
// ============================================================================
package cs_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 10;
  localparam int WIN = 9;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] MISR_POLY         = 16'h1021;
  localparam logic [15:0] MISR_INIT         = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cs_misr.sv
`default_nettype none
// ============================================================================
// cs_misr : 16-bit multiple-input signature register, enable + sync clear
// Revision: 1.0
// ============================================================================
module cs_misr
  import cs_pkg::*;
#(
  parameter int DW = Y_W
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic [15:0]   sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = MISR_INIT;
    end else if (en_i) begin
      sig_d = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000)) ^ 16'(data_i);
    end
  end

  always_ff @(posedge clk) begin
    sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule
`default_nettype wire

// File: rtl/cs_stream_source.sv
`default_nettype none
// ============================================================================
// cs_stream_source : LFSR stimulus source and MISR response compactor for CS
// Revision: 1.0
// ============================================================================
module cs_stream_source #(
  parameter int          N_PAT  = 2000,
  parameter int          WIN    = cs_pkg::WIN,
  parameter int          CS_LAT = 1,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [cs_pkg::X_W-1:0]  X,
  input  logic [cs_pkg::Y_W-1:0]  Y,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             y_count,
  output logic [15:0]             sig
);

  import cs_pkg::*;

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;
  localparam logic [31:0] LAST_TX   = 32'(N_PAT - 1);
  localparam logic [31:0] FILL_END  = 32'(WIN - 1);
  localparam logic [31:0] FLUSH_END = 32'(N_PAT + CS_LAT);

  state_t          state_q;
  logic [15:0]     lfsr_q;
  logic [31:0]     tx_q;
  logic [X_W-1:0]  x_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     cnt_q;
  logic [CS_LAT:0] line_q;

  logic launch_d;
  logic tag_d;
  logic capture_d;

  assign launch_d  = start && (state_q == IDLE || state_q == DONE);
  // tx_q is the index of the sample being emitted on this edge
  assign tag_d     = (state_q == FILL || state_q == RUN) && (tx_q >= FILL_END);
  assign capture_d = line_q[CS_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      tx_q    <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= FILL;
            lfsr_q  <= SEED_EFF;
            tx_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FILL, RUN: begin
          x_q    <= lfsr_q[X_W-1:0];
          lfsr_q <= lfsr_next(lfsr_q);
          tx_q   <= tx_q + 32'd1;
          if (tx_q == LAST_TX) begin
            state_q <= FLUSH;
          end else if (state_q == FILL && tx_q == FILL_END) begin
            state_q <= RUN;
          end
        end
        FLUSH: begin
          // tx_q keeps counting so it doubles as the drain timer
          tx_q <= tx_q + 32'd1;
          if (tx_q == FLUSH_END) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || launch_d) begin
      line_q <= '0;
    end else begin
      line_q[0] <= tag_d;
      for (int i = 1; i <= CS_LAT; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || launch_d) begin
      cnt_q <= '0;
    end else if (capture_d) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  cs_misr #(
    .DW (Y_W)
  ) u_misr (
    .clk    (clk),
    .clr_i  (reset || launch_d),
    .en_i   (capture_d),
    .data_i (Y),
    .sig_o  (sig)
  );

  assign X       = x_q;
  assign y_valid = capture_d;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_count = cnt_q;

endmodule
`default_nettype wire
